// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Parametrised UART transmitter with a small input FIFO and a
//                valid/ready handshake. Frame: start, DATA_BITS payload bits
//                (LSB first), optional parity bit, STOP_BITS stop bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 10416,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic [DATA_BITS-1:0]          data,
    output logic                          ready,
    output logic                          dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(BAUD_DIV * STOP_BITS) + 1;

    localparam logic [BAUD_W-1:0] c_cell_last = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] c_stop_last = BAUD_W'(BAUD_DIV * STOP_BITS - 1);
    localparam logic [2:0]        c_bit_last  = 3'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  c_full      = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   dout_q, dout_d;

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;

    logic                   w_push;
    logic                   w_pop;
    logic [DATA_BITS-1:0]   w_head;
    logic                   w_head_par;

    // ready depends only on registered occupancy, so a same-cycle pop never
    // opens the door for a write-through into a full FIFO.
    assign ready      = (count_q != c_full);
    assign w_push     = valid && ready;
    assign w_head     = mem_q[rd_ptr_q];
    assign w_head_par = (PARITY == 1) ? ~^w_head : ^w_head;

    assign dout       = dout_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);

    // FIFO storage: written on every accepted word, pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Transmitter state register; dout is registered from the current state
    // so it lags the FSM by one cycle and never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state, bit timing, FIFO pop and serial line value.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        w_pop   = 1'b0;
        dout_d  = 1'b1;

        case (state_q)
            S_IDLE: begin
                dout_d = 1'b1;
                baud_d = '0;
                if (count_q != '0) begin
                    w_pop   = 1'b1;
                    shift_d = w_head;
                    par_d   = w_head_par;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                dout_d = 1'b0;
                if (baud_q == c_cell_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                dout_d = shift_q[0];
                if (baud_q == c_cell_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == c_bit_last) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_PARITY: begin
                dout_d = par_q;
                if (baud_q == c_cell_last) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                dout_d = 1'b1;
                if (baud_q == c_stop_last) begin
                    baud_d = '0;
                    if (count_q != '0) begin
                        // Back-to-back frames: no idle cell between them.
                        w_pop   = 1'b1;
                        shift_d = w_head;
                        par_d   = w_head_par;
                        bit_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
